// File: rtl/spi_slave_rx.sv
// SPI slave receiver in the system clock domain: synchronises CS/SCK/MOSI, deserialises words in
// any SPI mode and bit order, and hands them downstream over a valid/ready handshake.
`timescale 1ns/1ps
module spi_slave_rx #(
    parameter int unsigned WORD_W      = 8,
    parameter int unsigned MSB_FIRST   = 0,
    parameter int unsigned CPOL        = 0,
    parameter int unsigned CPHA        = 0,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cs_i,
    input  logic              sck_i,
    input  logic              mosi_i,
    output logic [WORD_W-1:0] rx_data_o,
    output logic              rx_valid_o,
    input  logic              rx_ready_i,
    output logic              rx_overrun_o,
    output logic              frame_active_o,
    output logic              frame_done_o,
    output logic              frame_partial_o,
    output logic [15:0]       word_count_o
);

    localparam int unsigned CntW       = $clog2(WORD_W);
    localparam logic        SckIdle    = 1'(CPOL);
    localparam bit          SampleRise = (CPOL == CPHA);

    typedef enum logic [0:0] {StIdle, StShift} state_e;

    logic [SYNC_STAGES-1:0] cs_sync_q, sck_sync_q, mosi_sync_q;
    logic                   cs_prev_q, sck_prev_q;

    state_e                 state_q;
    logic [CntW-1:0]        bit_cnt_q;
    logic [WORD_W-1:0]      shift_q, shift_d;
    logic [WORD_W-1:0]      rx_data_q;
    logic                   rx_valid_q, rx_overrun_q;
    logic                   frame_active_q, frame_done_q, frame_partial_q;
    logic [15:0]            word_count_q;

    logic cs_s, sck_s, mosi_s;
    logic cs_fall, cs_rise, sample_edge, word_done;

    // CS flops reset to the asserted level so a frame already running at reset release is ignored.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cs_sync_q   <= '0;
            sck_sync_q  <= {SYNC_STAGES{SckIdle}};
            mosi_sync_q <= '0;
            cs_prev_q   <= 1'b0;
            sck_prev_q  <= SckIdle;
        end else begin
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs_i};
            sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], sck_i};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi_i};
            cs_prev_q   <= cs_sync_q[SYNC_STAGES-1];
            sck_prev_q  <= sck_sync_q[SYNC_STAGES-1];
        end
    end

    always_comb begin
        cs_s        = cs_sync_q[SYNC_STAGES-1];
        sck_s       = sck_sync_q[SYNC_STAGES-1];
        mosi_s      = mosi_sync_q[SYNC_STAGES-1];
        cs_fall     = cs_prev_q & ~cs_s;
        cs_rise     = ~cs_prev_q & cs_s;
        sample_edge = SampleRise ? (sck_s & ~sck_prev_q) : (~sck_s & sck_prev_q);
        word_done   = (bit_cnt_q == CntW'(WORD_W - 1));
        if (MSB_FIRST != 0) begin
            shift_d = {shift_q[WORD_W-2:0], mosi_s};
        end else begin
            shift_d = {mosi_s, shift_q[WORD_W-1:1]};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q         <= StIdle;
            bit_cnt_q       <= '0;
            shift_q         <= '0;
            rx_data_q       <= '0;
            rx_valid_q      <= 1'b0;
            rx_overrun_q    <= 1'b0;
            frame_active_q  <= 1'b0;
            frame_done_q    <= 1'b0;
            frame_partial_q <= 1'b0;
            word_count_q    <= '0;
        end else begin
            frame_done_q <= 1'b0;
            if (rx_valid_q && rx_ready_i) begin
                rx_valid_q <= 1'b0;
            end
            case (state_q)
                StIdle: begin
                    if (cs_fall) begin
                        state_q        <= StShift;
                        bit_cnt_q      <= '0;
                        shift_q        <= '0;
                        word_count_q   <= '0;
                        rx_overrun_q   <= 1'b0;
                        frame_active_q <= 1'b1;
                    end
                end
                StShift: begin
                    // A CS rise in the same cycle as a sample edge ends the frame; the edge is dropped.
                    if (cs_rise) begin
                        state_q         <= StIdle;
                        frame_active_q  <= 1'b0;
                        frame_done_q    <= 1'b1;
                        frame_partial_q <= (bit_cnt_q != '0);
                    end else if (sample_edge) begin
                        shift_q <= shift_d;
                        if (word_done) begin
                            bit_cnt_q <= '0;
                            if (word_count_q != 16'hFFFF) begin
                                word_count_q <= word_count_q + 16'd1;
                            end
                            if (!rx_valid_q || rx_ready_i) begin
                                rx_data_q  <= shift_d;
                                rx_valid_q <= 1'b1;
                            end else begin
                                rx_overrun_q <= 1'b1;
                            end
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign rx_data_o       = rx_data_q;
    assign rx_valid_o      = rx_valid_q;
    assign rx_overrun_o    = rx_overrun_q;
    assign frame_active_o  = frame_active_q;
    assign frame_done_o    = frame_done_q;
    assign frame_partial_o = frame_partial_q;
    assign word_count_o    = word_count_q;

endmodule
